// File: rtl/sn74ls540_regpipe_if.sv
// Control and data bus for sn74ls540_regpipe: input word, load/output enables and fill status.
interface sn74ls540_regpipe_if #(
    parameter int W = 8
);
    logic [W-1:0] a;
    logic         le_;
    logic         g1_;
    logic         g2_;
    logic         rdy;

    modport master (output a, le_, g1_, g2_, input rdy);
    modport slave  (input a, le_, g1_, g2_, output rdy);
endinterface

// File: rtl/sn74ls540_regpipe.sv
// Registered '540/'541-style bus driver: DEPTH-stage load-enabled pipeline feeding a two-enable tristate output.
// Define SN74LS540_REGPIPE_OE_SYNC_EN to register g1_/g2_ before they reach the output driver.
module sn74ls540_regpipe #(
    parameter int W      = 8,
    parameter int DEPTH  = 2,
    parameter bit INVERT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    sn74ls540_regpipe_if.slave   bus,
    output logic [W-1:0]         q_
);
    if (DEPTH < 1) begin : g_depth_chk
        $error("sn74ls540_regpipe: DEPTH must be >= 1");
    end

    localparam int              PW   = DEPTH * W;
    localparam int              FW   = $clog2(DEPTH + 1);
    localparam logic [FW-1:0]   FULL = FW'(DEPTH);

    // Stage 0 occupies the low W bits; the oldest stage sits at the top.
    logic [PW-1:0] pipe_q, pipe_d;
    logic [FW-1:0] fill_q, fill_d;

    always_comb begin
        pipe_d = pipe_q;
        fill_d = fill_q;
        if (bus.le_ == 1'b0) begin
            pipe_d = PW'({pipe_q, bus.a});
            if (fill_q != FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end else if (bus.le_ == 1'b1) begin
            pipe_d = pipe_q;
        end else begin
            pipe_d = 'x;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '0;
            fill_q <= '0;
        end else begin
            pipe_q <= pipe_d;
            fill_q <= fill_d;
        end
    end

    assign bus.rdy = (fill_q == FULL);

    logic [W-1:0] last_w;
    logic [W-1:0] dout;
    assign last_w = pipe_q[PW-1 -: W];
    assign dout   = INVERT ? ~last_w : last_w;

    logic g1_eff, g2_eff;
`ifdef SN74LS540_REGPIPE_OE_SYNC_EN
    logic g1_q, g2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            g1_q <= 1'b1;
            g2_q <= 1'b1;
        end else begin
            g1_q <= bus.g1_;
            g2_q <= bus.g2_;
        end
    end

    assign g1_eff = g1_q;
    assign g2_eff = g2_q;
`else
    assign g1_eff = bus.g1_;
    assign g2_eff = bus.g2_;
`endif

    // hiz is 1 when either enable is high, 0 when both are low, x otherwise (drives all x).
    logic hiz;
    assign hiz = g1_eff | g2_eff;
    assign q_  = (hiz == 1'b1) ? {W{1'bz}} :
                 ((hiz == 1'b0) ? dout : {W{1'bx}});
endmodule
